// File: rtl/uart_tx.sv
// UART transmitter on the 16x-baud clock: one-entry holding buffer feeding a
// start / data (LSB first) / optional parity / stop serialiser.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_16bd,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 Tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          PAR_EN    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_d;
  logic                   tick_wrap;
  logic                   take;
  logic                   buf_full_q;
  logic [DATA_BITS-1:0]   buf_data_q;

  // Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready.
  // tx_ready is simply "holding buffer empty", so a write can never coincide
  // with the FSM draining the buffer (drain requires it to be full).
  assign tx_ready   = !buf_full_q;
  assign busy       = (state_q != IDLE);
  assign tick_wrap  = (tick_q == TICK_LAST);
  assign frame_done = (state_q == STOP) && tick_wrap && (stop_q == STOP_LAST);

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else if (take) begin
      buf_full_q <= 1'b0;
    end else if (tx_valid && !buf_full_q) begin
      buf_full_q <= 1'b1;
      buf_data_q <= tx_data;
    end
  end

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      Tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      Tx      <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          take    = 1'b1;
          state_d = START;
          tick_d  = '0;
          shift_d = buf_data_q;
          par_d   = (^buf_data_q) ^ PAR_ODD;
        end
      end
      START: begin
        if (tick_wrap) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_wrap) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            stop_d  = 1'b0;
            state_d = PAR_EN ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PARITY: begin
        if (tick_wrap) begin
          tick_d  = '0;
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_wrap) begin
          tick_d = '0;
          if (stop_q == STOP_LAST) begin
            // A byte waiting in the buffer starts immediately, with no idle gap.
            if (buf_full_q) begin
              take    = 1'b1;
              state_d = START;
              shift_d = buf_data_q;
              par_d   = (^buf_data_q) ^ PAR_ODD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // Tx is registered: its next value follows the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed bytes with hand-computed parity; a line monitor
// decodes each frame off Tx and checks it against an expected queue.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       valid_w [3];
  logic [7:0] data_w  [3];
  logic       rdy_w   [3];
  logic       tx_w    [3];
  logic       busy_w  [3];
  logic       fd_w    [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_q_odd[$];
  logic [8:0] exp_q_np[$];
  int starts0[$];

  uart_tx dut (
    .clk_16bd(clk), .rst(rst), .tx_valid(valid_w[0]), .tx_data(data_w[0]),
    .tx_ready(rdy_w[0]), .Tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0])
  );

  uart_tx #(.PARITY_ODD(1)) dut_odd (
    .clk_16bd(clk), .rst(rst), .tx_valid(valid_w[1]), .tx_data(data_w[1]),
    .tx_ready(rdy_w[1]), .Tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1])
  );

  uart_tx #(.PARITY_EN(0)) dut_np (
    .clk_16bd(clk), .rst(rst), .tx_valid(valid_w[2]), .tx_data(data_w[2]),
    .tx_ready(rdy_w[2]), .Tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500us;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return exp_q.size();
      1:       return exp_q_odd.size();
      default: return exp_q_np.size();
    endcase
  endfunction

  task automatic monitor(input int id, input bit has_par);
    int         nb;
    logic [10:0] bits;
    bit         shape_ok, fd_ok, aborted, have;
    logic       v;
    logic [8:0] e;
    nb = has_par ? 11 : 10;
    v = 1'b1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx_w[id] !== 1'b0) continue;
      if (id == 0) starts0.push_back(cyc);
      shape_ok = 1'b1; fd_ok = 1'b1; aborted = 1'b0; bits = '1;
      for (int b = 0; b < nb; b++) begin
        for (int s = 0; s < 16; s++) begin
          if (b != 0 || s != 0) @(negedge clk);
          if (rst !== 1'b0) begin aborted = 1'b1; break; end
          if (s == 0) v = tx_w[id];
          else if (tx_w[id] !== v) shape_ok = 1'b0;
          if (busy_w[id] !== 1'b1) shape_ok = 1'b0;
          if (fd_w[id] !== ((b == nb - 1) && (s == 15))) fd_ok = 1'b0;
        end
        if (aborted) break;
        bits[b] = v;
      end
      if (aborted) continue;
      have = 1'b1;
      e = '0;
      case (id)
        0: if (exp_q.size() > 0) e = exp_q.pop_front(); else have = 1'b0;
        1: if (exp_q_odd.size() > 0) e = exp_q_odd.pop_front(); else have = 1'b0;
        default: if (exp_q_np.size() > 0) e = exp_q_np.pop_front(); else have = 1'b0;
      endcase
      check($sformatf("mon%0d_frame_expected", id), 32'(have), 32'd1);
      if (have) begin
        check($sformatf("mon%0d_data", id), 32'(bits[8:1]), 32'(e[7:0]));
        if (has_par) check($sformatf("mon%0d_parity", id), 32'(bits[9]), 32'(e[8]));
        check($sformatf("mon%0d_stop", id), 32'(bits[nb-1]), 32'd1);
        check($sformatf("mon%0d_bit_shape_busy", id), 32'(shape_ok), 32'd1);
        check($sformatf("mon%0d_frame_done_pos", id), 32'(fd_ok), 32'd1);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int id, input logic [7:0] d, output int n);
    int t;
    t = 0;
    @(negedge clk);
    while (rdy_w[id] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("send%0d_ready_timeout", id), 32'(t < 1000), 32'd1);
    valid_w[id] = 1'b1;
    data_w[id]  = d;
    @(negedge clk);
    n = cyc;
    valid_w[id] = 1'b0;
    data_w[id]  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input int id);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(busy_w[id] === 1'b0 && rdy_w[id] === 1'b1 && qsize(id) == 0) && t < 3000);
    check($sformatf("idle%0d_timeout", id), 32'(t < 3000), 32'd1);
  endtask

  task automatic wait_fd(input int id, input int n, input int len);
    int t;
    t = 0;
    while (fd_w[id] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("fd%0d_cycle", id), 32'(cyc - n), 32'(len));
  endtask

  typedef struct { logic [7:0] d; logic p; } vec_t;
  vec_t loop_vecs[3] = '{'{8'h00, 1'b0}, '{8'hFF, 1'b0}, '{8'hA5, 1'b0}};

  // ---------------- main sequence ----------------
  initial begin
    int n, n2;
    for (int i = 0; i < 3; i++) begin
      valid_w[i] = 1'b0;
      data_w[i]  = 8'h00;
    end
    rst = 1'b1;
    fork
      monitor(0, 1'b1);
      monitor(1, 1'b1);
      monitor(2, 1'b0);
    join_none

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_w[0]), 32'd1);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_frame_done", 32'(fd_w[0]), 32'd0);
    check("rst_ready", 32'(rdy_w[0]), 32'd1);
    check("rst_tx_odd", 32'(tx_w[1]), 32'd1);
    check("rst_tx_np", 32'(tx_w[2]), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte D5: five ones, even parity bit = 1
    exp_q.push_back({1'b1, 8'hD5});
    send(0, 8'hD5, n);
    check("single_ready_low_at_accept", 32'(rdy_w[0]), 32'd0);
    check("single_tx_high_at_accept", 32'(tx_w[0]), 32'd1);
    @(negedge clk);
    check("single_tx_start_n1", 32'(tx_w[0]), 32'd0);
    check("single_ready_back_n1", 32'(rdy_w[0]), 32'd1);
    check("single_busy_n1", 32'(busy_w[0]), 32'd1);
    wait_fd(0, n, 176);
    check("single_busy_at_fd", 32'(busy_w[0]), 32'd1);
    @(negedge clk);
    check("single_busy_fall", 32'(busy_w[0]), 32'd0);
    check("single_fd_one_cycle", 32'(fd_w[0]), 32'd0);
    wait_idle(0);

    // Back-to-back 41 then 42 (both even parity 0), plus backpressured FF
    starts0.delete();
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b0, 8'h42});
    @(negedge clk);
    valid_w[0] = 1'b1;
    data_w[0]  = 8'h41;
    @(negedge clk);
    n = cyc;
    check("b2b_ready_low_after_first", 32'(rdy_w[0]), 32'd0);
    data_w[0] = 8'h42;
    @(negedge clk);
    check("b2b_ready_after_drain", 32'(rdy_w[0]), 32'd1);
    @(negedge clk);
    check("b2b_ready_low_buffer_full", 32'(rdy_w[0]), 32'd0);
    valid_w[0] = 1'b0;
    data_w[0]  = 8'h00;
    @(negedge clk);
    valid_w[0] = 1'b1;
    data_w[0]  = 8'hFF;
    @(negedge clk);
    valid_w[0] = 1'b0;
    check("bp_ready_still_low", 32'(rdy_w[0]), 32'd0);
    wait_idle(0);
    check("b2b_frame_count", 32'(starts0.size()), 32'd2);
    if (starts0.size() == 2) begin
      check("b2b_first_start", 32'(starts0[0] - n), 32'd1);
      check("b2b_no_gap", 32'(starts0[1] - starts0[0]), 32'd176);
    end

    // Reset mid-DATA (bit 1 of 00 is low on the line)
    send(0, 8'h00, n);
    while (cyc < n + 40) @(negedge clk);
    check("pre_rst_data_tx_low", 32'(tx_w[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_data_tx", 32'(tx_w[0]), 32'd1);
    check("rst_data_busy", 32'(busy_w[0]), 32'd0);
    check("rst_data_ready", 32'(rdy_w[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-STOP with a second byte sitting in the buffer
    send(0, 8'h00, n);
    send(0, 8'h55, n2);
    while (cyc < n + 168) @(negedge clk);
    check("pre_rst_stop_ready_low", 32'(rdy_w[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_stop_tx", 32'(tx_w[0]), 32'd1);
    check("rst_stop_busy", 32'(busy_w[0]), 32'd0);
    check("rst_stop_ready", 32'(rdy_w[0]), 32'd1);
    check("rst_stop_fd", 32'(fd_w[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();

    // Receive-side style frames: 00, FF, A5 (all even parity 0)
    foreach (loop_vecs[i]) begin
      exp_q.push_back({loop_vecs[i].p, loop_vecs[i].d});
      send(0, loop_vecs[i].d, n);
    end
    wait_idle(0);

    // Odd parity: 03 has two ones -> parity bit 1
    exp_q_odd.push_back({1'b1, 8'h03});
    send(1, 8'h03, n);
    wait_idle(1);

    // No parity: 160-cycle frame
    exp_q_np.push_back({1'b0, 8'h96});
    send(2, 8'h96, n);
    wait_fd(2, n, 160);
    wait_idle(2);

    check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("end_exp_q_odd_empty", 32'(exp_q_odd.size()), 32'd0);
    check("end_exp_q_np_empty", 32'(exp_q_np.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
